// File: rtl/lii_arb_pkg.sv
// lii_arb_pkg: shared state encoding and default width for the LII TX arbiter
package lii_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam int LII_DATA_WIDTH = 64;

endpackage

// File: rtl/lii_arb_rr2.sv
// lii_arb_rr2: two-way round-robin picker; the port not granted last wins a tie
module lii_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // a lone requester always wins, on a tie the port other than last wins
    always_comb begin
        gnt[0] = req[0] && (!req[1] || last);
        gnt[1] = req[1] && (!req[0] || !last);
    end

endmodule

// File: rtl/lii_tx_arbiter.sv
// lii_tx_arbiter: merges two LII packet streams onto one, switching only at packet
// boundaries; optional per-port packet counters under LII_ARB_STATS_EN
module lii_tx_arbiter
    import lii_arb_pkg::*;
#(
    parameter int DATA_WIDTH       = LII_DATA_WIDTH,
    parameter int BYTES_VLD_LENGTH = $clog2(DATA_WIDTH/8)+1,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic [DATA_WIDTH-1:0]       RX0_DATA,
    input  logic [BYTES_VLD_LENGTH-1:0] RX0_BYTES_VLD,
    input  logic                        RX0_SOF,
    input  logic                        RX0_EOF,
    input  logic                        RX0_VLD,
    output logic                        RX0_RDY,
    input  logic [DATA_WIDTH-1:0]       RX1_DATA,
    input  logic [BYTES_VLD_LENGTH-1:0] RX1_BYTES_VLD,
    input  logic                        RX1_SOF,
    input  logic                        RX1_EOF,
    input  logic                        RX1_VLD,
    output logic                        RX1_RDY,
    output logic [DATA_WIDTH-1:0]       TX_DATA,
    output logic [BYTES_VLD_LENGTH-1:0] TX_BYTES_VLD,
    output logic                        TX_SOF,
    output logic                        TX_EOF,
    output logic                        TX_VLD,
    input  logic                        TX_RDY
`ifdef LII_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]        STAT_PKT0,
    output logic [CNT_WIDTH-1:0]        STAT_PKT1
`endif
);

    arb_state_t state;
    logic       last;
    logic [1:0] vld, sof, eof, req, gnt;
    logic       lock, sel, hit;

    assign vld = {RX1_VLD, RX0_VLD};
    assign sof = {RX1_SOF, RX0_SOF};
    assign eof = {RX1_EOF, RX0_EOF};
    assign req = (state == IDLE) ? (vld & sof) : 2'b00;

    lii_arb_rr2 u_rr (
        .req  (req),
        .last (last),
        .gnt  (gnt)
    );

    // select the connected port and whether its word is forwarded this cycle
    always_comb begin
        lock = state != IDLE;
        sel  = (state == LOCK1) || (!lock && gnt[1]);
        hit  = lock ? (vld[sel] && !sof[sel]) : |gnt;
    end

    // zero-latency datapath; words outside packet framing are consumed but not forwarded
    always_comb begin
        RX0_RDY      = RESET_N && TX_RDY && (lock ? !sel : (gnt[0] || (vld[0] && !sof[0])));
        RX1_RDY      = RESET_N && TX_RDY && (lock ?  sel : (gnt[1] || (vld[1] && !sof[1])));
        TX_VLD       = RESET_N && hit;
        TX_DATA      = sel ? RX1_DATA : RX0_DATA;
        TX_BYTES_VLD = !TX_VLD ? '0 : sel ? RX1_BYTES_VLD : RX0_BYTES_VLD;
        TX_SOF       = TX_VLD && sof[sel];
        TX_EOF       = TX_VLD && eof[sel];
    end

    // packet lock state and last-granted port advance only on an accepted word
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            last  <= 1'b1;
        end else if (TX_RDY && hit) begin
            state <= eof[sel] ? IDLE : sel ? LOCK1 : LOCK0;
            last  <= sel;
        end
    end

`ifdef LII_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] cnt0, cnt1;

    // count packets completed per source port, wrapping naturally
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (TX_RDY && hit && eof[sel]) begin
            if (sel) cnt1 <= cnt1 + CNT_WIDTH'(1);
            else     cnt0 <= cnt0 + CNT_WIDTH'(1);
        end
    end

    assign STAT_PKT0 = cnt0;
    assign STAT_PKT1 = cnt1;
`endif

endmodule

// File: tb/tb_lii_tx_arbiter.sv
// tb_lii_tx_arbiter: directed and random stimulus checked against a packet-level model
module tb_lii_tx_arbiter;

    localparam int DW = 64;
    localparam int BW = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_rdy = 1'b0;
    logic [DW-1:0] data  [2];
    logic [BW-1:0] bytes [2];
    logic          sof   [2];
    logic          eof   [2];
    logic          vld   [2];
    logic          rdy0, rdy1, tx_sof, tx_eof, tx_vld;
    logic [DW-1:0] tx_data;
    logic [BW-1:0] tx_bytes;
    logic [CW-1:0] stat0, stat1;
    logic [CW-1:0] pkts [2];

    int tests = 0;
    int fails = 0;
    int owner = -1;
    int last  = 1;

    lii_tx_arbiter dut (
        .CLK           (clk),
        .RESET_N       (rst_n),
        .RX0_DATA      (data[0]),
        .RX0_BYTES_VLD (bytes[0]),
        .RX0_SOF       (sof[0]),
        .RX0_EOF       (eof[0]),
        .RX0_VLD       (vld[0]),
        .RX0_RDY       (rdy0),
        .RX1_DATA      (data[1]),
        .RX1_BYTES_VLD (bytes[1]),
        .RX1_SOF       (sof[1]),
        .RX1_EOF       (eof[1]),
        .RX1_VLD       (vld[1]),
        .RX1_RDY       (rdy1),
        .TX_DATA       (tx_data),
        .TX_BYTES_VLD  (tx_bytes),
        .TX_SOF        (tx_sof),
        .TX_EOF        (tx_eof),
        .TX_VLD        (tx_vld),
        .TX_RDY        (tx_rdy)
`ifdef LII_ARB_STATS_EN
        ,
        .STAT_PKT0     (stat0),
        .STAT_PKT1     (stat1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic s, input logic e);
        vld[i]   = v;
        sof[i]   = s;
        eof[i]   = e;
        data[i]  = {32'(i + 1), $urandom};
        bytes[i] = BW'($urandom_range(8));
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 2; i++)
            drive(i, $urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(4) < 2);
        tx_rdy = $urandom_range(4) != 0;
    endtask

    // model: a free output goes to a pending SOF (alternating on ties), an owned one
    // forwards only the owner's continuation words; stray words are swallowed
    task automatic run_cycle();
        int   win;
        logic p0, p1, e0, e1;
        #1;
        win = -1;
        e0  = 1'b0;
        e1  = 1'b0;
        if (rst_n) begin
            if (owner < 0) begin
                p0  = vld[0] && sof[0];
                p1  = vld[1] && sof[1];
                win = (p0 && p1) ? 1 - last : p0 ? 0 : p1 ? 1 : -1;
                e0  = tx_rdy && (win == 0 || (vld[0] && !sof[0]));
                e1  = tx_rdy && (win == 1 || (vld[1] && !sof[1]));
            end else begin
                win = (vld[owner] && !sof[owner]) ? owner : -1;
                e0  = tx_rdy && owner == 0;
                e1  = tx_rdy && owner == 1;
            end
        end
        chk("tx_vld", tx_vld, win >= 0);
        chk("rx0_rdy", rdy0, e0);
        chk("rx1_rdy", rdy1, e1);
        chk("tx_sof", tx_sof, win < 0 ? 1'b0 : sof[win]);
        chk("tx_eof", tx_eof, win < 0 ? 1'b0 : eof[win]);
        chk("tx_bytes", tx_bytes, win < 0 ? BW'(0) : bytes[win]);
        if (win >= 0) chk("tx_data", tx_data, data[win]);
        if (!rst_n) begin
            owner   = -1;
            last    = 1;
            pkts[0] = '0;
            pkts[1] = '0;
        end else if (tx_rdy && win >= 0) begin
            last  = win;
            owner = eof[win] ? -1 : win;
            if (eof[win]) pkts[win] = pkts[win] + 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        pkts[0] = '0;
        pkts[1] = '0;
        stat0   = '0;
        stat1   = '0;
        // reset with busy inputs: nothing may be granted or consumed
        rand_inputs();
        drive(0, 1, 1, 0);
        drive(1, 1, 1, 0);
        tx_rdy = 1'b1;
        for (int c = 0; c < 2; c++) run_cycle();
        rst_n = 1'b1;
        // single-word packets on both ports alternate, port 0 first
        for (int c = 0; c < 6; c++) begin
            drive(0, 1, 1, 1);
            drive(1, 1, 1, 1);
            #1;
            chk("alt_port", tx_data, data[c % 2]);
            run_cycle();
        end
        // port 1 waits behind port 0's 4-word packet, then goes right after EOF
        for (int c = 0; c < 5; c++) begin
            drive(0, c < 4, c == 0, c == 3);
            drive(1, c >= 1, 1, 1);
            #1;
            if (c == 4) chk("b2b_sof_port1", {tx_sof, tx_data}, {1'b1, data[1]});
            run_cycle();
        end
        // sink stall mid-packet freezes everything
        for (int c = 0; c < 6; c++) begin
            tx_rdy = !(c >= 1 && c <= 3);
            drive(0, 1, c == 0, c == 5);
            drive(1, 1, 1, 0);
            #1;
            if (!tx_rdy) chk("stall_rdy", {rdy0, rdy1}, 2'b00);
            run_cycle();
        end
        tx_rdy = 1'b1;
        // second SOF inside a packet is swallowed
        for (int c = 0; c < 4; c++) begin
            drive(0, 1, c == 0 || c == 2, c == 3);
            drive(1, 0, 0, 0);
            #1;
            if (c == 2) chk("dup_sof_drop", {tx_vld, rdy0}, 2'b01);
            run_cycle();
        end
        // reset while port 1 holds the output
        drive(0, 0, 0, 0);
        drive(1, 1, 1, 0);
        run_cycle();
        drive(1, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("reset_tx_vld", tx_vld, 1'b0);
        run_cycle();
        rst_n = 1'b1;
        drive(0, 1, 1, 1);
        drive(1, 1, 1, 1);
        #1;
        chk("post_reset_gnt", {rdy0, rdy1}, 2'b10);
        run_cycle();
        // random traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            rand_inputs();
            rst_n = $urandom_range(99) != 0;
            run_cycle();
        end
        rst_n = 1'b1;
`ifdef LII_ARB_STATS_EN
        chk("stat_pkt0", stat0, pkts[0]);
        chk("stat_pkt1", stat1, pkts[1]);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lii_tx_arbiter.md
LII_TX_ARBITER -- requirements
Module: lii_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 64, output and per-port data width in bits; a multiple of 8 and at least 16.
REQ-002 Parameter BYTES_VLD_LENGTH, $clog2(DATA_WIDTH/8)+1, width of the BYTES_VLD fields.
REQ-003 Parameter CNT_WIDTH, 32, width of each statistics counter.
REQ-004 Port CLK, input, 1, the single clock; all logic is on its rising edge.
REQ-005 Port RESET_N, input, 1, asynchronous active-low reset.
REQ-006 Ports RX<i>_DATA / RX<i>_BYTES_VLD / RX<i>_SOF / RX<i>_EOF / RX<i>_VLD, inputs, DATA_WIDTH / BYTES_VLD_LENGTH / 1 / 1 / 1, for i = 0,1: requester LII words plus a word-valid flag.
REQ-007 Port RX<i>_RDY, output, 1, per port: the word on port i is consumed this cycle.
REQ-008 Ports TX_DATA / TX_BYTES_VLD / TX_SOF / TX_EOF / TX_VLD, outputs, DATA_WIDTH / BYTES_VLD_LENGTH / 1 / 1 / 1: the merged LII stream.
REQ-009 Port TX_RDY, input, 1, the sink accepts the TX word this cycle.
REQ-010 Ports STAT_PKT0 / STAT_PKT1, outputs, CNT_WIDTH each; present only with LII_ARB_STATS_EN.

Function
REQ-011 The block shall merge two LII packet streams onto one, switching only at packet boundaries.
REQ-012 States: IDLE, LOCK0, LOCK1; reset state IDLE.
REQ-013 In IDLE, a requester is pending when RX<i>_VLD && RX<i>_SOF.
REQ-014 In IDLE, grant goes combinationally to the pending port with round-robin priority; register LAST (reset 1) names the last granted port, and the other port wins ties.
REQ-015 Transfer: TX_* mirrors the granted port's RX_*; RX<g>_RDY = TX_RDY; the ungranted RX_RDY = 0.
REQ-016 A transfer with SOF && !EOF moves IDLE to LOCK<g> and updates LAST to g.
REQ-017 A transfer with SOF && EOF (single-word packet) updates LAST and stays in IDLE.
REQ-018 In LOCK<g>, the datapath is connected to port g only.
REQ-019 In LOCK<g>, a transfer with EOF returns to IDLE in the next cycle.
REQ-020 In LOCK<g>, a word from port g with SOF=1 is dropped (RX<g>_RDY=1, TX_VLD=0) and the state is kept.
REQ-021 In IDLE, a valid word without SOF is dropped in the same way.
REQ-022 TX_VLD = 0 whenever no granted word is valid; TX_DATA is then don't-care, and TX_SOF, TX_EOF and TX_BYTES_VLD are 0.
REQ-023 Latency is zero cycles; there are no data registers, only state and LAST.
REQ-024 Back-to-back packets are allowed: the cycle after EOF (in IDLE) may transfer the next SOF.
REQ-025 With TX_RDY=0, state, grant and LAST are frozen and every RX_RDY = 0.

Reset
REQ-026 Assertion of RESET_N=0 shall immediately force state IDLE, LAST=1, all RX_RDY=0, TX_VLD=0, and the counters to 0.
REQ-027 A packet in flight at reset shall be abandoned; after release, arbitration restarts with port 0 having priority.

Configuration
REQ-028 With macro LII_ARB_STATS_EN defined, STAT_PKT0/1 shall increment by 1 on each transferred EOF from that port, wrapping to 0 at 2^CNT_WIDTH.
REQ-029 Without LII_ARB_STATS_EN, neither the STAT ports nor the counter logic shall exist.

Structure
REQ-030 Package lii_arb_pkg shall hold the state enum (IDLE, LOCK0, LOCK1) and the default DATA_WIDTH constant.
REQ-031 Sub-module lii_arb_rr2 (2-way round-robin picker: req[1:0], last, gnt[1:0]) shall be instantiated once.

Verification
REQ-032 Both ports present a 1-word packet every cycle, TX_RDY=1 -> TX alternates port 0,1,0,1..., with LAST starting at 1.
REQ-033 Port 0 sends a 4-word packet while port 1 raises SOF at cycle 1 -> port 1's SOF appears at cycle 4, immediately after port 0's EOF.
REQ-034 TX_RDY held 0 for 3 cycles mid-packet -> TX word unchanged, both RX_RDY=0, state kept; transfer resumes at TX_RDY=1.
REQ-035 Port 0 sends a second SOF inside a packet -> that word dropped, TX_VLD=0 that cycle, packet completes normally.
REQ-036 RESET_N pulsed low in LOCK1 -> next cycle IDLE, TX_VLD=0; with both ports pending, port 0 is granted first.
REQ-037 With LII_ARB_STATS_EN, after 5 packets from port 0 and 3 from port 1 -> STAT_PKT0=5, STAT_PKT1=3; a counter preloaded via force to all-ones wraps to 0.
